// File: rtl/x_branch_stage.sv
// Execute-stage branch resolution: resolves branches/JAL/JALR, issues the
// redirect pulse, kills the wrong-path slot and registers results downstream.
module x_branch_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dx_valid_i,
    output logic             dx_ready_o,
    input  logic [XLEN-1:0]  dx_pc_i,
    input  logic [XLEN-1:0]  dx_rs1_i,
    input  logic [XLEN-1:0]  dx_rs2_i,
    input  logic [XLEN-1:0]  dx_imm_i,
    input  logic [2:0]       dx_funct3_i,
    input  logic             dx_is_branch_i,
    input  logic             dx_is_jal_i,
    input  logic             dx_is_jalr_i,
    output logic             xm_valid_o,
    input  logic             xm_ready_i,
    output logic [XLEN-1:0]  xm_result_o,
    output logic [2:0]       xm_funct3_o,
    output logic             xm_zero_o,
    output logic             xm_ltz_o,
    output logic             branchtaken,
    output logic [XLEN-1:0]  BranchALUXpipe_out,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic {RUN, FLUSH} stateT;

    stateT           state;
    stateT           stateNext;
    logic            accept;
    logic            load;
    logic            redirect;
    logic            cond;
    logic            taken;
    logic            isLink;
    logic            eq;
    logic            ltS;
    logic            ltU;
    logic [XLEN-1:0] sumRs1;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;

    // The slot after a redirect is always swallowed, even under backpressure.
    assign dx_ready_o = (state == FLUSH) | ~xm_valid_o | xm_ready_i;
    assign accept     = dx_valid_i & dx_ready_o;
    assign load       = accept & (state == RUN);

    assign eq  = (dx_rs1_i == dx_rs2_i);
    assign ltS = ($signed(dx_rs1_i) < $signed(dx_rs2_i));
    assign ltU = (dx_rs1_i < dx_rs2_i);

    always_comb begin
        cond = 1'b0;
        case (dx_funct3_i)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = ltS;
            3'b101:  cond = ~ltS;
            3'b110:  cond = ltU;
            3'b111:  cond = ~ltU;
            default: cond = 1'b0;
        endcase
    end

    assign taken    = dx_is_jalr_i | dx_is_jal_i | (dx_is_branch_i & cond);
    assign redirect = load & taken;
    assign isLink   = dx_is_jalr_i | dx_is_jal_i;
    assign sumRs1   = dx_rs1_i + dx_imm_i;

    always_comb begin
        target = dx_pc_i + dx_imm_i;
        if (dx_is_jalr_i) begin
            target = {sumRs1[XLEN-1:1], 1'b0};
        end
    end

    always_comb begin
        result = sumRs1;
        if (isLink) begin
            result = dx_pc_i + XLEN'(4);
        end else if (dx_is_branch_i) begin
            result = '0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (redirect) stateNext = FLUSH;
            FLUSH:   stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            xm_valid_o  <= 1'b0;
            xm_result_o <= '0;
            xm_funct3_o <= '0;
            xm_zero_o   <= 1'b0;
            xm_ltz_o    <= 1'b0;
        end else if (load) begin
            xm_valid_o  <= 1'b1;
            xm_result_o <= result;
            xm_funct3_o <= dx_funct3_i;
            xm_zero_o   <= eq;
            xm_ltz_o    <= ltS;
        end else if (xm_ready_i) begin
            xm_valid_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            branchtaken        <= 1'b0;
            BranchALUXpipe_out <= '0;
            taken_cnt_o        <= '0;
        end else begin
            branchtaken <= redirect;
            if (redirect) begin
                BranchALUXpipe_out <= target;
                taken_cnt_o        <= taken_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_x_branch_stage.sv
// Scoreboard bench for x_branch_stage: directed vectors push expectations,
// a negedge monitor pops them on output transfers and redirect pulses.
module tb_x_branch_stage;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  f3;
        logic        z;
        logic        l;
    } outExpT;

    typedef struct {
        logic [63:0] tgt;
        logic [31:0] cnt;
    } rdExpT;

    logic        clk;
    logic        reset_i;
    logic        dx_valid_i;
    logic        dx_ready_o;
    logic [63:0] dx_pc_i;
    logic [63:0] dx_rs1_i;
    logic [63:0] dx_rs2_i;
    logic [63:0] dx_imm_i;
    logic [2:0]  dx_funct3_i;
    logic        dx_is_branch_i;
    logic        dx_is_jal_i;
    logic        dx_is_jalr_i;
    logic        xm_valid_o;
    logic        xm_ready_i;
    logic [63:0] xm_result_o;
    logic [2:0]  xm_funct3_o;
    logic        xm_zero_o;
    logic        xm_ltz_o;
    logic        branchtaken;
    logic [63:0] BranchALUXpipe_out;
    logic [31:0] taken_cnt_o;

    outExpT outQ[$];
    rdExpT  rdQ[$];
    int     checks = 0;
    int     passes = 0;
    logic [31:0] expCnt = 0;
    int     w;

    x_branch_stage dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .dx_valid_i         (dx_valid_i),
        .dx_ready_o         (dx_ready_o),
        .dx_pc_i            (dx_pc_i),
        .dx_rs1_i           (dx_rs1_i),
        .dx_rs2_i           (dx_rs2_i),
        .dx_imm_i           (dx_imm_i),
        .dx_funct3_i        (dx_funct3_i),
        .dx_is_branch_i     (dx_is_branch_i),
        .dx_is_jal_i        (dx_is_jal_i),
        .dx_is_jalr_i       (dx_is_jalr_i),
        .xm_valid_o         (xm_valid_o),
        .xm_ready_i         (xm_ready_i),
        .xm_result_o        (xm_result_o),
        .xm_funct3_o        (xm_funct3_o),
        .xm_zero_o          (xm_zero_o),
        .xm_ltz_o           (xm_ltz_o),
        .branchtaken        (branchtaken),
        .BranchALUXpipe_out (BranchALUXpipe_out),
        .taken_cnt_o        (taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        outExpT e;
        rdExpT  r;
        if (!reset_i) begin
            if (xm_valid_o && xm_ready_i) begin
                if (outQ.size() == 0) begin
                    checks++;
                    $display("FAIL out_unexpected: got result %h, want no output", xm_result_o);
                end else begin
                    e = outQ.pop_front();
                    chk("out_result", xm_result_o, e.res);
                    chk("out_funct3", 64'(xm_funct3_o), 64'(e.f3));
                    chk("out_zero", 64'(xm_zero_o), 64'(e.z));
                    chk("out_ltz", 64'(xm_ltz_o), 64'(e.l));
                end
            end
            if (branchtaken) begin
                if (rdQ.size() == 0) begin
                    checks++;
                    $display("FAIL redirect_unexpected: got target %h, want no pulse", BranchALUXpipe_out);
                end else begin
                    r = rdQ.pop_front();
                    chk("rd_target", BranchALUXpipe_out, r.tgt);
                    chk("rd_count", 64'(taken_cnt_o), 64'(r.cnt));
                end
            end
        end
    end

    task automatic drive(input logic [63:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                         input logic br, jal, jalr, input bit keep,
                         input logic [63:0] eRes, input logic eZ, eL, eTk,
                         input logic [63:0] eTgt, output int waits);
        logic rdy;
        dx_valid_i     = 1'b1;
        dx_pc_i        = pc;
        dx_rs1_i       = rs1;
        dx_rs2_i       = rs2;
        dx_imm_i       = imm;
        dx_funct3_i    = f3;
        dx_is_branch_i = br;
        dx_is_jal_i    = jal;
        dx_is_jalr_i   = jalr;
        if (keep) begin
            outQ.push_back('{eRes, f3, eZ, eL});
            if (eTk) begin
                expCnt++;
                rdQ.push_back('{eTgt, expCnt});
            end
        end
        waits = 0;
        forever begin
            @(negedge clk);
            rdy = dx_ready_o;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                checks++;
                $display("FAIL accept_timeout: got no accept after %0d cycles, want accept", waits);
                break;
            end
        end
        dx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        dx_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        dx_valid_i = 0; dx_pc_i = 0; dx_rs1_i = 0; dx_rs2_i = 0; dx_imm_i = 0;
        dx_funct3_i = 0; dx_is_branch_i = 0; dx_is_jal_i = 0; dx_is_jalr_i = 0;
        xm_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        idle(5);

        chk("rst_valid", 64'(xm_valid_o), 64'd0);
        chk("rst_result", xm_result_o, 64'd0);
        chk("rst_funct3", 64'(xm_funct3_o), 64'd0);
        chk("rst_zero", 64'(xm_zero_o), 64'd0);
        chk("rst_ltz", 64'(xm_ltz_o), 64'd0);
        chk("rst_taken", 64'(branchtaken), 64'd0);
        chk("rst_target", BranchALUXpipe_out, 64'd0);
        chk("rst_cnt", 64'(taken_cnt_o), 64'd0);
        chk("rst_ready", 64'(dx_ready_o), 64'd1);

        // BEQ taken, then a wrong-path slot that must vanish
        drive(64'h100, 64'd7, 64'd7, 64'd16, 3'b000, 1, 0, 0, 1,
              64'd0, 1, 0, 1, 64'h110, w);
        drive(64'h104, 64'd1, 64'd2, 64'd3, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);
        chk("flush_ready_wait", 64'(w), 64'd0);
        chk("flush_no_load", 64'(xm_valid_o), 64'd0);

        // BLTU not taken, BLT taken back-to-back
        drive(64'h300, '1, 64'd1, 64'h20, 3'b110, 1, 0, 0, 1,
              64'd0, 0, 1, 0, 64'd0, w);
        drive(64'h304, '1, 64'd1, 64'h20, 3'b100, 1, 0, 0, 1,
              64'd0, 0, 1, 1, 64'h324, w);
        chk("b2b_after_bltu", 64'(w), 64'd0);
        drive(64'h308, 64'd0, 64'd0, 64'd0, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);

        // JALR clears bit 0 of the target
        drive(64'h200, 64'h1001, 64'd0, 64'd4, 3'b000, 0, 0, 1, 1,
              64'h204, 0, 0, 1, 64'h1004, w);
        drive(64'h204, 64'd0, 64'd0, 64'd0, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);

        // plain ALU add, then JAL with wrap-around
        drive(64'h400, 64'h10, 64'h20, 64'h8, 3'b000, 0, 0, 0, 1,
              64'h18, 0, 1, 0, 64'd0, w);
        drive(64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 64'd5, 64'd8, 3'b000, 0, 1, 0, 1,
              64'd0, 1, 0, 1, 64'h4, w);
        drive(64'h0, 64'd0, 64'd0, 64'd0, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);

        // BNE equal operands, BGEU taken with negative offset, funct3 010
        drive(64'h480, 64'd3, 64'd3, 64'h40, 3'b001, 1, 0, 0, 1,
              64'd0, 1, 0, 0, 64'd0, w);
        drive(64'h500, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 3'b111, 1, 0, 0, 1,
              64'd0, 0, 1, 1, 64'h4F8, w);
        drive(64'h504, 64'd0, 64'd0, 64'd0, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);
        drive(64'h4F8, 64'd0, 64'd0, 64'h10, 3'b010, 1, 0, 0, 1,
              64'd0, 1, 0, 0, 64'd0, w);

        // all flags set: JALR wins
        drive(64'h600, 64'h2000, 64'h2000, 64'h10, 3'b001, 1, 1, 1, 1,
              64'h604, 1, 0, 1, 64'h2010, w);
        drive(64'h604, 64'd0, 64'd0, 64'd0, 3'b000, 0, 0, 0, 0,
              64'd0, 0, 0, 0, 64'd0, w);
        idle(3);

        // downstream stall
        xm_ready_i = 1'b0;
        drive(64'h700, 64'd1, 64'd2, 64'd1, 3'b000, 0, 0, 0, 1,
              64'd2, 0, 1, 0, 64'd0, w);
        dx_valid_i = 1'b1; dx_pc_i = 64'h704; dx_rs1_i = 64'd9; dx_rs2_i = 64'd9;
        dx_imm_i = 64'd1; dx_funct3_i = 3'b000;
        dx_is_branch_i = 0; dx_is_jal_i = 0; dx_is_jalr_i = 0;
        outQ.push_back('{64'd10, 3'b000, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(dx_ready_o), 64'd0);
            chk("stall_valid", 64'(xm_valid_o), 64'd1);
            chk("stall_result", xm_result_o, 64'd2);
        end
        @(posedge clk);
        #1 xm_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(dx_ready_o), 64'd1);
        @(posedge clk);
        #1 dx_valid_i = 1'b0;
        idle(2);

        // asynchronous reset while the redirect pulse is high
        drive(64'h800, 64'd0, 64'd0, 64'h40, 3'b000, 0, 1, 0, 1,
              64'h804, 1, 0, 1, 64'h840, w);
        chk("pre_rst_pulse", 64'(branchtaken), 64'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("arst_taken", 64'(branchtaken), 64'd0);
        chk("arst_valid", 64'(xm_valid_o), 64'd0);
        chk("arst_cnt", 64'(taken_cnt_o), 64'd0);
        outQ.delete();
        rdQ.delete();
        expCnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_i = 1'b0;

        drive(64'h900, 64'd4, 64'd3, 64'd4, 3'b000, 0, 0, 0, 1,
              64'd8, 0, 0, 0, 64'd0, w);
        chk("post_rst_accept", 64'(w), 64'd0);
        drive(64'h910, 64'd0, 64'd0, 64'h10, 3'b000, 1, 0, 0, 1,
              64'd0, 1, 0, 1, 64'h920, w);
        idle(4);

        chk("outq_drained", 64'(outQ.size()), 64'd0);
        chk("rdq_drained", 64'(rdQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
